// File: rtl/frogger_pkg.sv
// Shared game constants: FSM state encoding, default lives limits and
// CLOCK_50-derived timing.
package frogger_pkg;

  // Lives manager state encoding
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PLAY     = 2'd1;
  localparam logic [1:0] RESPAWN  = 2'd2;
  localparam logic [1:0] GAMEOVER = 2'd3;

  localparam int unsigned CLOCK_50_HZ            = 50_000_000;
  localparam int unsigned LIVES_INIT_DEFAULT     = 5;
  localparam int unsigned LIVES_MAX_DEFAULT      = 7;
  // One second of CLOCK_50
  localparam int unsigned RESPAWN_CYCLES_DEFAULT = CLOCK_50_HZ;

endpackage

// File: rtl/cc_respawn_timer.sv
// Up-counter with synchronous clear and enable. Counts COUNT_CYCLES enabled
// clocks, then wraps to zero.
//   clk, rst_n      : clock, asynchronous active-low reset
//   clear           : force count to zero (wins over enable)
//   enable          : advance the count this cycle
//   tcPulse_c       : combinational, high on the enabled cycle that ends the window
module cc_respawn_timer #(
  parameter int unsigned COUNT_CYCLES    = 50_000_000,
  parameter int unsigned COUNT_DATAWIDTH = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tcPulse_c
);

  logic [COUNT_DATAWIDTH-1:0] count;

  // Terminal count only fires while enabled, so a pause holds it off
  assign tcPulse_c = enable && (count == COUNT_DATAWIDTH'(COUNT_CYCLES - 1));

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || tcPulse_c) begin
      count <= '0;
    end else if (enable) begin
      count <= count + COUNT_DATAWIDTH'(1);
    end
  end

endmodule

// File: rtl/cc_lives_manager.sv
// Owns the frog's lives count: loads it on start, decrements on a hit,
// saturates bonus lives, runs a post-death respawn window and flags game over.
//   CLOCK_50 / RESET_InLow : clock, asynchronous active-low reset
//   start/hit/bonus        : one-cycle pulses; start has top priority
//   pause                  : level, freezes the respawn window
//   lives_Out              : current lives count
//   playing/respawn        : high in PLAY / RESPAWN
//   gameover_OutLow        : low in GAMEOVER
//   death_OutHigh          : one-cycle pulse per accepted hit
module cc_lives_manager
  import frogger_pkg::*;
#(
  parameter int unsigned LIVES_DATAWIDTH   = 3,
  parameter int unsigned LIVES_INIT        = LIVES_INIT_DEFAULT,
  parameter int unsigned LIVES_MAX         = LIVES_MAX_DEFAULT,
  parameter int unsigned RESPAWN_CYCLES    = RESPAWN_CYCLES_DEFAULT,
  parameter int unsigned RESPAWN_DATAWIDTH = 26
) (
  input  logic                       CC_LIVES_MANAGER_CLOCK_50,
  input  logic                       CC_LIVES_MANAGER_RESET_InLow,
  input  logic                       CC_LIVES_MANAGER_start_InHigh,
  input  logic                       CC_LIVES_MANAGER_hit_InHigh,
  input  logic                       CC_LIVES_MANAGER_bonus_InHigh,
  input  logic                       CC_LIVES_MANAGER_pause_InHigh,
  output logic [LIVES_DATAWIDTH-1:0] CC_LIVES_MANAGER_lives_Out,
  output logic                       CC_LIVES_MANAGER_playing_OutHigh,
  output logic                       CC_LIVES_MANAGER_respawn_OutHigh,
  output logic                       CC_LIVES_MANAGER_gameover_OutLow,
  output logic                       CC_LIVES_MANAGER_death_OutHigh
);

  localparam logic [LIVES_DATAWIDTH-1:0] LIVES_ONE     = LIVES_DATAWIDTH'(1);
  localparam logic [LIVES_DATAWIDTH-1:0] LIVES_INIT_W  = LIVES_DATAWIDTH'(LIVES_INIT);
  localparam logic [LIVES_DATAWIDTH-1:0] LIVES_MAX_W   = LIVES_DATAWIDTH'(LIVES_MAX);

  logic                       clk;
  logic                       rst_n;
  logic [1:0]                 state;
  logic [1:0]                 stateNext;
  logic [LIVES_DATAWIDTH-1:0] lives;
  logic [LIVES_DATAWIDTH-1:0] livesNext;
  logic [LIVES_DATAWIDTH-1:0] livesInc;
  logic                       deathNext;
  logic                       timerClear;
  logic                       timerEnable;
  logic                       timerDone_c;

  assign clk   = CC_LIVES_MANAGER_CLOCK_50;
  assign rst_n = CC_LIVES_MANAGER_RESET_InLow;

  // Respawn window advances only while in RESPAWN and not paused
  assign timerEnable = (state == RESPAWN) && !CC_LIVES_MANAGER_pause_InHigh;

  cc_respawn_timer #(
    .COUNT_CYCLES   (RESPAWN_CYCLES),
    .COUNT_DATAWIDTH(RESPAWN_DATAWIDTH)
  ) respawnTimer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (timerClear),
    .enable   (timerEnable),
    .tcPulse_c(timerDone_c)
  );

  // Saturating bonus increment
  assign livesInc = (lives >= LIVES_MAX_W) ? LIVES_MAX_W : lives + LIVES_ONE;

  // Next-state and lives update
  always_comb begin
    stateNext  = state;
    livesNext  = lives;
    deathNext  = 1'b0;
    timerClear = 1'b0;
    if (CC_LIVES_MANAGER_start_InHigh) begin
      stateNext  = PLAY;
      livesNext  = LIVES_INIT_W;
      timerClear = 1'b1;
    end else begin
      case (state)
        PLAY: begin
          if (CC_LIVES_MANAGER_hit_InHigh) begin
            deathNext  = 1'b1;
            timerClear = 1'b1;
            if (CC_LIVES_MANAGER_bonus_InHigh) begin
              // Bonus re-adds the life just lost; at one life it saves the game
              stateNext = RESPAWN;
              livesNext = (lives <= LIVES_ONE) ? LIVES_ONE : lives;
            end else if (lives <= LIVES_ONE) begin
              stateNext = GAMEOVER;
              livesNext = '0;
            end else begin
              stateNext = RESPAWN;
              livesNext = lives - LIVES_ONE;
            end
          end else if (CC_LIVES_MANAGER_bonus_InHigh) begin
            livesNext = livesInc;
          end
        end
        RESPAWN: begin
          if (CC_LIVES_MANAGER_bonus_InHigh) begin
            livesNext = livesInc;
          end
          if (timerDone_c) begin
            stateNext = PLAY;
          end
        end
        GAMEOVER: begin
          livesNext = '0;
        end
        default: begin
          stateNext = state;
        end
      endcase
    end
  end

  // State, lives and output decode registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                            <= IDLE;
      lives                            <= '0;
      CC_LIVES_MANAGER_lives_Out       <= '0;
      CC_LIVES_MANAGER_playing_OutHigh <= 1'b0;
      CC_LIVES_MANAGER_respawn_OutHigh <= 1'b0;
      CC_LIVES_MANAGER_gameover_OutLow <= 1'b1;
      CC_LIVES_MANAGER_death_OutHigh   <= 1'b0;
    end else begin
      state                            <= stateNext;
      lives                            <= livesNext;
      CC_LIVES_MANAGER_lives_Out       <= livesNext;
      CC_LIVES_MANAGER_playing_OutHigh <= (stateNext == PLAY);
      CC_LIVES_MANAGER_respawn_OutHigh <= (stateNext == RESPAWN);
      CC_LIVES_MANAGER_gameover_OutLow <= (stateNext != GAMEOVER);
      CC_LIVES_MANAGER_death_OutHigh   <= deathNext;
    end
  end

endmodule
